// File: rtl/fpga_transmitter_if.sv
// Handshake bundle between the word source/partner side and the serial link transmitter.
// master drives the request and acknowledge lines; slave is the transmitter.
interface fpga_transmitter_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             acknowledge;
  logic             send;
  logic             finish;
  logic             data_out;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    output start, data_in, acknowledge,
    input  send, finish, data_out, busy, done, error
  );

  modport slave (
    input  start, data_in, acknowledge,
    output send, finish, data_out, busy, done, error
  );
endinterface

// File: rtl/fpga_transmitter.sv
// Transmit side of the board-to-board link: opens a session, serialises a word
// MSB-first with one send/acknowledge handshake per bit, then closes the session.
module fpga_transmitter #(
  parameter int WIDTH       = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  fpga_transmitter_if.slave   link
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] BIT_CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] BIT_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_CNT_ZERO = CNT_W'(0);
  localparam logic [TMO_W-1:0] TMO_ONE      = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_ZERO     = TMO_W'(0);
  localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_OPEN      = 4'd1,
    S_OPEN_WAIT = 4'd2,
    S_SETUP     = 4'd3,
    S_BIT       = 4'd4,
    S_BIT_WAIT  = 4'd5,
    S_FIN       = 4'd6,
    S_FIN_WAIT  = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shift_r, shift_s;
  logic [CNT_W-1:0] bit_cnt_r, bit_cnt_s;
  logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_s;
  logic             ack_meta_r, ack_sync_r, ack_dly_r;
  logic             ack_seen_s, tmo_hit_s, timeout_s;
  logic             in_wait_r_s, in_wait_next_s;
  logic             send_r, finish_r, data_out_r, busy_r, done_r, error_r;
  logic             send_s, finish_s, data_out_s, busy_s, done_s;

  assign ack_seen_s = ack_sync_r & ~ack_dly_r;
  assign tmo_hit_s  = (tmo_cnt_r == TMO_LAST);

  // Two-flop synchroniser plus edge detector on the partner's acknowledge pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack_meta_r <= 1'b0;
      ack_sync_r <= 1'b0;
      ack_dly_r  <= 1'b0;
    end else begin
      ack_meta_r <= link.acknowledge;
      ack_sync_r <= ack_meta_r;
      ack_dly_r  <= ack_sync_r;
    end
  end

  // Next-state, datapath and next-output logic; outputs are registered below.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    bit_cnt_s = bit_cnt_r;
    timeout_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (link.start) begin
          shift_s   = link.data_in;
          bit_cnt_s = BIT_CNT_INIT;
          state_s   = S_OPEN;
        end else begin
          state_s   = S_IDLE;
        end
      end
      S_OPEN:  state_s = S_OPEN_WAIT;
      S_SETUP: state_s = S_BIT;
      S_BIT:   state_s = S_BIT_WAIT;
      S_FIN:   state_s = S_FIN_WAIT;
      S_DONE:  state_s = S_IDLE;
      S_OPEN_WAIT, S_BIT_WAIT, S_FIN_WAIT: begin
        // A synchronised ack in the limit cycle still counts as a response.
        if (ack_seen_s) begin
          if (state_r == S_OPEN_WAIT) begin
            state_s = S_SETUP;
          end else if (state_r == S_FIN_WAIT) begin
            state_s = S_DONE;
          end else begin
            shift_s   = shift_r << 1'b1;
            bit_cnt_s = bit_cnt_r - BIT_CNT_ONE;
            state_s   = (bit_cnt_s == BIT_CNT_ZERO) ? S_FIN : S_SETUP;
          end
        end else if (tmo_hit_s) begin
          timeout_s = 1'b1;
          state_s   = S_IDLE;
        end else begin
          state_s   = state_r;
        end
      end
      default: state_s = S_IDLE;
    endcase

    in_wait_r_s    = (state_r == S_OPEN_WAIT) || (state_r == S_BIT_WAIT) || (state_r == S_FIN_WAIT);
    in_wait_next_s = (state_s == S_OPEN_WAIT) || (state_s == S_BIT_WAIT) || (state_s == S_FIN_WAIT);
    if (in_wait_r_s && in_wait_next_s) begin
      tmo_cnt_s = tmo_cnt_r + TMO_ONE;
    end else begin
      tmo_cnt_s = TMO_ZERO;
    end

    send_s   = (state_s == S_OPEN) || (state_s == S_BIT);
    finish_s = (state_s == S_FIN);
    done_s   = (state_s == S_DONE);
    busy_s   = (state_s != S_IDLE);
    // The bit is presented in SETUP and held until its acknowledge is consumed.
    case (state_s)
      S_SETUP:           data_out_s = shift_s[WIDTH-1];
      S_BIT, S_BIT_WAIT: data_out_s = data_out_r;
      default:           data_out_s = 1'b0;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      shift_r    <= '0;
      bit_cnt_r  <= BIT_CNT_ZERO;
      tmo_cnt_r  <= TMO_ZERO;
      send_r     <= 1'b0;
      finish_r   <= 1'b0;
      data_out_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      bit_cnt_r  <= bit_cnt_s;
      tmo_cnt_r  <= tmo_cnt_s;
      send_r     <= send_s;
      finish_r   <= finish_s;
      data_out_r <= data_out_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      error_r    <= timeout_s;
    end
  end

  assign link.send     = send_r;
  assign link.finish   = finish_r;
  assign link.data_out = data_out_r;
  assign link.busy     = busy_r;
  assign link.done     = done_r;
  assign link.error    = error_r;
endmodule

// File: tb/tb_fpga_transmitter.sv
// Scoreboarded bench: directed words, a modelled partner that acks each send/finish,
// and a monitor that matches every send/finish/done/error pulse against a queue.
module tb_fpga_transmitter;
  localparam int WIDTH       = 8;
  localparam int ACK_TIMEOUT = 16;
  localparam logic [1:0] EV_SEND = 2'd0;
  localparam logic [1:0] EV_FIN  = 2'd1;
  localparam logic [1:0] EV_DONE = 2'd2;
  localparam logic [1:0] EV_ERR  = 2'd3;

  logic clock = 1'b0;
  logic reset;

  fpga_transmitter_if #(.WIDTH(WIDTH)) link ();

  fpga_transmitter #(.WIDTH(WIDTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .link  (link)
  );

  always #5 clock = ~clock;

  int n_checks      = 0;
  int n_pass        = 0;
  int cyc           = 0;
  int ack_delay     = 2;
  int ack_limit     = -1;
  int acks_given    = 0;
  int stray_cnt     = 0;
  int stray_seen    = 0;
  int last_send_cyc = 0;
  int done_cnt      = 0;
  logic [2:0] exp_q[$];

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_eq(input string name, input int act, input int exp);
    check(act == exp, name, act, exp);
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    exp_q.push_back({EV_SEND, 1'b0});
    for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back({EV_SEND, w[i]});
    exp_q.push_back({EV_FIN, 1'b0});
    exp_q.push_back({EV_DONE, 1'b0});
  endtask

  task automatic score(input logic [2:0] ev);
    logic [2:0] e;
    if (exp_q.size() == 0) begin
      check(1'b0, "unexpected_event", int'(ev), -1);
    end else begin
      e = exp_q.pop_front();
      check(ev == e, "event", int'(ev), int'(e));
    end
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Monitor: every output pulse is checked against the scoreboard queue.
  initial begin
    logic prev_dout;
    prev_dout = 1'b0;
    forever begin
      @(negedge clock);
      if (link.send || link.finish)
        check_eq("send_finish_exclusive", int'(link.send & link.finish), 0);
      if (link.send) begin
        last_send_cyc = cyc;
        check_eq("dout_stable_setup_to_send", int'(link.data_out), int'(prev_dout));
        score({EV_SEND, link.data_out});
      end
      if (link.finish) score({EV_FIN, link.data_out});
      if (link.done) begin
        done_cnt++;
        score({EV_DONE, link.data_out});
      end
      if (link.error) score({EV_ERR, link.data_out});
      prev_dout = link.data_out;
    end
  end

  // Partner receiver model: one-cycle ack (ack_delay+1) cycles after each send/finish.
  initial begin
    int countdown;
    countdown = -1;
    link.acknowledge = 1'b0;
    forever begin
      @(negedge clock);
      link.acknowledge = 1'b0;
      if (reset) begin
        countdown = -1;
      end else if (countdown == 0) begin
        link.acknowledge = 1'b1;
        acks_given++;
        countdown = -1;
      end else if (countdown > 0) begin
        countdown--;
      end
      if (!reset && (link.send || link.finish) && (ack_limit < 0 || acks_given < ack_limit))
        countdown = ack_delay;
      if (stray_cnt != stray_seen) begin
        link.acknowledge = 1'b1;
        stray_seen = stray_cnt;
      end
    end
  end

  task automatic start_word(input logic [WIDTH-1:0] w);
    link.data_in = w;
    link.start   = 1'b1;
    @(negedge clock);
    link.start   = 1'b0;
    link.data_in = ~w;
    check_eq("accept_busy", int'(link.busy), 1);
    check_eq("accept_send", int'(link.send), 1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clock);
      k++;
    end
    check_eq({name, "_drain"}, exp_q.size(), 0);
    @(negedge clock);
    check_eq({name, "_idle_busy"}, int'(link.busy), 0);
  endtask

  task automatic wait_sends(input int n, input int budget);
    int seen;
    int k;
    seen = 0;
    k = 0;
    while (seen < n && k < budget) begin
      @(negedge clock);
      k++;
      if (link.send) seen++;
    end
    check_eq("wait_sends", seen, n);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!link.done && k < budget) begin
      @(negedge clock);
      k++;
    end
    check_eq("wait_done", int'(link.done), 1);
  endtask

  task automatic wait_error(input int budget);
    int k;
    k = 0;
    while (!link.error && k < budget) begin
      @(negedge clock);
      k++;
    end
    check_eq("wait_error", int'(link.error), 1);
  endtask

  initial begin
    int d0;
    int busy_seen;
    reset        = 1'b1;
    link.start   = 1'b0;
    link.data_in = '0;
    repeat (3) @(negedge clock);
    check_eq("reset_outputs", int'({link.send, link.finish, link.data_out,
                                     link.busy, link.done, link.error}), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Nominal word.
    push_word(8'hA5);
    start_word(8'hA5);
    wait_drain(400, "nominal");

    // Back-to-back words, second start in the cycle after done.
    d0 = done_cnt;
    push_word(8'hFF);
    push_word(8'h00);
    start_word(8'hFF);
    wait_done(400);
    @(negedge clock);
    start_word(8'h00);
    wait_drain(400, "back_to_back");
    check_eq("back_to_back_done_count", done_cnt - d0, 2);

    // Timeout: partner acks the open and bits 1..3 only.
    ack_limit = acks_given + 4;
    exp_q.push_back({EV_SEND, 1'b0});
    exp_q.push_back({EV_SEND, 1'b1});
    exp_q.push_back({EV_SEND, 1'b1});
    exp_q.push_back({EV_SEND, 1'b0});
    exp_q.push_back({EV_SEND, 1'b0});
    exp_q.push_back({EV_ERR,  1'b0});
    start_word(8'hC3);
    wait_error(400);
    check_eq("timeout_latency", cyc - last_send_cyc, ACK_TIMEOUT + 1);
    @(negedge clock);
    check_eq("timeout_busy_after", int'(link.busy), 0);
    check_eq("timeout_error_one_cycle", int'(link.error), 0);
    wait_drain(50, "timeout");
    ack_limit = -1;
    repeat (10) @(negedge clock);

    // Stray start during bit 2, then a stray ack while idle.
    push_word(8'h96);
    start_word(8'h96);
    wait_sends(2, 100);
    link.start   = 1'b1;
    link.data_in = 8'h3C;
    @(negedge clock);
    link.start   = 1'b0;
    wait_drain(400, "busy_start");
    stray_cnt++;
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (link.busy) busy_seen++;
    end
    check_eq("stray_ack_no_session", busy_seen, 0);

    // Asynchronous reset between edges during bit 5.
    push_word(8'h39);
    start_word(8'h39);
    wait_sends(5, 200);
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    check_eq("async_reset_outputs", int'({link.send, link.finish, link.data_out,
                                           link.busy, link.done, link.error}), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check_eq("post_reset_idle", int'(link.busy), 0);
    push_word(8'h5A);
    start_word(8'h5A);
    wait_drain(400, "post_reset");

    // Every acknowledge lands on the last allowed wait cycle.
    ack_delay = ACK_TIMEOUT - 3;
    push_word(8'h6B);
    start_word(8'h6B);
    wait_drain(800, "ack_tie");
    ack_delay = 2;

    repeat (5) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
